// File: rtl/count_defs_pkg.sv
// Shared definitions for the count checker and its benches: FSM state type and default widths.
package count_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int MATCH_W   = 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that either saturates at all-ones or wraps modulo 2^W.
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(SAT && (count == '1))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Monitors an upstream counter, locks onto a correct increment sequence and
// reports sequence errors and max-to-0 wraps as pulses and statistics.
module count_checker
  import count_defs::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = 2,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_en,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  state_t             state;
  logic [WIDTH-1:0]   prev;
  logic [MATCH_W-1:0] match_cnt;
  logic [WIDTH-1:0]   expected;
  logic               hit;
  logic               err_inc;
  logic               wrap_inc;

  // A matching zero can only follow prev == max, so no separate prev test is needed.
  always_comb begin
    expected = prev + WIDTH'(1);
    hit      = (count_in == expected);
    err_inc  = count_en && (state == TRACK) && !hit;
    wrap_inc = count_en && (state != IDLE) && hit && (count_in == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= err_inc;
      wrap_pulse <= wrap_inc;
      if (count_en) begin
        prev <= count_in;
        case (state)
          IDLE: begin
            match_cnt <= '0;
            state     <= SYNC;
            locked    <= 1'b0;
          end
          SYNC: begin
            if (hit) begin
              match_cnt <= match_cnt + MATCH_W'(1);
              if ((match_cnt + MATCH_W'(1)) >= MATCH_W'(LOCK_N)) begin
                state  <= TRACK;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          TRACK: begin
            if (!hit) begin
              match_cnt <= '0;
              state     <= SYNC;
              locked    <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W   (STAT_W),
    .SAT (1'b1)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(
    .W   (STAT_W),
    .SAT (1'b0)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_count_checker.sv
// Directed and randomized checks of count_checker against a sequence-level reference model.
module tb_count_checker;

  localparam int WIDTH  = 4;
  localparam int LOCK_N = 2;
  localparam int STAT_W = 8;
  localparam int MODV   = 1 << WIDTH;
  localparam int SMAX   = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  count_in;
  logic              count_en;
  logic              locked;
  logic              err_pulse;
  logic              wrap_pulse;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;

  int tests = 0;
  int fails = 0;

  // Reference model: sequence history expressed with plain integers.
  bit m_seeded, m_locked, m_ep, m_wp;
  int m_prev, m_run, m_err, m_wrap;

  count_checker #(
    .WIDTH  (WIDTH),
    .LOCK_N (LOCK_N),
    .STAT_W (STAT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .count_en   (count_en),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_ep = 0; m_wp = 0;
    m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_sample(input bit en, input int s);
    bit ok;
    m_ep = 0;
    m_wp = 0;
    if (!en) return;
    if (!m_seeded) begin
      m_seeded = 1;
      m_prev   = s;
      m_run    = 0;
      return;
    end
    ok = (s == (m_prev + 1) % MODV);
    if (ok) begin
      if (s == 0) begin
        m_wp   = 1;
        m_wrap = (m_wrap + 1) % (SMAX + 1);
      end
      if (!m_locked) begin
        m_run++;
        if (m_run >= LOCK_N) m_locked = 1;
      end
    end else begin
      if (m_locked) begin
        m_ep = 1;
        if (m_err < SMAX) m_err++;
        m_locked = 0;
      end
      m_run = 0;
    end
    m_prev = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("err_pulse", {31'd0, err_pulse}, {31'd0, m_ep});
    check("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, m_wp});
    check("err_count", 32'(err_count), 32'(m_err));
    check("wrap_count", 32'(wrap_count), 32'(m_wrap));
  endtask

  task automatic step(input bit en, input int s);
    @(negedge clk);
    count_en = en;
    count_in = WIDTH'(s);
    @(posedge clk);
    #1;
    model_sample(en, s);
    check_all();
  endtask

  initial begin
    int p;
    rst      = 1'b1;
    count_en = 1'b0;
    count_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_wrap_count", 32'(wrap_count), 32'd0);
    rst = 1'b0;

    // Lock on 5,6,7
    step(1, 5);
    step(1, 6);
    check("not_locked_after_6", {31'd0, locked}, 32'd0);
    step(1, 7);
    check("locked_after_7", {31'd0, locked}, 32'd1);
    check("err_zero_after_lock", 32'(err_count), 32'd0);

    // Correct wrap 14,15,0
    for (int v = 8; v <= 15; v++) step(1, v);
    step(1, 0);
    check("wrap_pulse_on_0", {31'd0, wrap_pulse}, 32'd1);
    check("wrap_count_1", 32'(wrap_count), 32'd1);
    check("no_err_on_wrap", {31'd0, err_pulse}, 32'd0);

    // Error at prev=3, then relock on 10,11
    step(1, 1);
    step(1, 2);
    step(1, 3);
    step(1, 9);
    check("err_pulse_on_9", {31'd0, err_pulse}, 32'd1);
    check("err_count_1", 32'(err_count), 32'd1);
    check("unlocked_after_err", {31'd0, locked}, 32'd0);
    step(1, 10);
    check("err_pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
    step(1, 11);
    check("relocked_after_11", {31'd0, locked}, 32'd1);

    // Enable low: input ignored
    for (int i = 0; i < 5; i++) step(0, int'($urandom_range(0, MODV - 1)));
    check("hold_locked", {31'd0, locked}, 32'd1);
    check("hold_err_count", 32'(err_count), 32'd1);
    check("hold_wrap_count", 32'(wrap_count), 32'd1);

    // 300 forced errors: break then relock
    for (int i = 0; i < 300; i++) begin
      p = m_prev;
      step(1, (p + 5) % MODV);
      check("forced_err_pulse", {31'd0, err_pulse}, 32'd1);
      step(1, (p + 6) % MODV);
      step(1, (p + 7) % MODV);
    end
    check("err_count_saturated", 32'(err_count), 32'd255);

    // Randomized traffic, biased toward correct increments
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        step(($urandom_range(0, 4) != 0), (m_prev + 1) % MODV);
      else
        step(($urandom_range(0, 4) != 0), int'($urandom_range(0, MODV - 1)));
    end

    // Asynchronous reset mid-TRACK
    for (int i = 0; i < 3; i++) step(1, (m_prev + 1) % MODV);
    check("locked_before_async_rst", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_locked", {31'd0, locked}, 32'd0);
    check("async_rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("async_rst_wrap_pulse", {31'd0, wrap_pulse}, 32'd0);
    check("async_rst_err_count", 32'(err_count), 32'd0);
    check("async_rst_wrap_count", 32'(wrap_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 9);
    check("reseed_only", {31'd0, locked}, 32'd0);
    step(1, 10);
    step(1, 11);
    check("lock_after_reseed", {31'd0, locked}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
